// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its matching SIPO receiver.
package piso_serializer_pkg;

    // Raw state encodings, kept explicit so both link ends agree on them.
    localparam logic IDLE_ENC  = 1'b0;
    localparam logic SHIFT_ENC = 1'b1;

    typedef enum logic {
        IDLE  = IDLE_ENC,
        SHIFT = SHIFT_ENC
    } state_e;

    // Width of a bit-position counter covering 0 .. data_width-1.
    function automatic int unsigned count_width(input int unsigned data_width);
        return (data_width > 1) ? int'($clog2(data_width)) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: counts accepted beats within a word.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned CNT_W      = count_width(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST_POS   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] BEFORE_END = CNT_W'(DATA_WIDTH - 2);

    // Count register; clear wins over enable so a new word always starts at 0.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST_POS)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal flag registered alongside the count (count == DATA_WIDTH-1).
    always_ff @(posedge clk) begin
        if (clear) begin
            terminal <= 1'b0;
        end else if (enable && (count != LAST_POS)) begin
            terminal <= (count == BEFORE_END);
        end
    end

endmodule

// File: rtl/piso_serializer_32_bit.sv
// Parallel-in serial-out serializer: loads a word over valid/ready and shifts it
// out one bit per accepted serial beat, flagging the first and last bit.
module piso_serializer_32_bit
    import piso_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    input  logic                  Serial_Ready_In,
    output logic                  Frame_Start_Out,
    output logic                  Frame_End_Out,
    output logic                  Busy_Out
);

    localparam int unsigned CNT_W = count_width(DATA_WIDTH);

    state_e                  state;
    state_e                  state_nxt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]        bit_count;
    logic                    bit_terminal;
    logic                    in_shift;
    logic                    load_accept;
    logic                    beat_accept;
    logic                    last_beat;
    logic                    cnt_clear;
    logic                    cnt_enable;

    // Handshake qualifiers.
    assign in_shift    = (state == SHIFT);
    assign load_accept = Load_Valid_In & Load_Ready_Out;
    assign beat_accept = Serial_Valid_Out & Serial_Ready_In;
    assign last_beat   = beat_accept & bit_terminal;

    // Counter restarts on reset, on a new word, and after the final beat so it
    // never runs past DATA_WIDTH-1.
    assign cnt_clear  = Reset_In | load_accept | last_beat;
    assign cnt_enable = beat_accept;

    piso_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk      (Clk_In),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (bit_count),
        .terminal (bit_terminal)
    );

    // Serial side outputs decode directly from state, count and shift register.
    assign Busy_Out         = in_shift;
    assign Serial_Valid_Out = in_shift;
    assign Frame_Start_Out  = in_shift & (bit_count == '0);
    assign Frame_End_Out    = in_shift & bit_terminal;
    assign Serial_Data_Out  = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];

    // Ready when idle, or when the last bit leaves this cycle so words chain
    // with no idle gap; a combinational path from Serial_Ready_In by design.
    assign Load_Ready_Out = ~Reset_In & (~in_shift | (Frame_End_Out & Serial_Ready_In));

    // State register.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a load wins over returning to IDLE on the last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (load_accept) begin
                    state_nxt = SHIFT;
                end else if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register: capture on load, shift toward the output on each beat.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            shreg <= '0;
        end else if (load_accept) begin
            shreg <= Parallel_Data_In;
        end else if (beat_accept) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer_32_bit.sv
// Directed bench for the serializer: an MSB-first and an LSB-first instance share
// stimulus; a cycle model plus bit queues supply every expected value.
module tb_piso_serializer_32_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pdata;
    logic        lvalid;
    logic        sready;

    logic a_lr, a_sd, a_sv, a_fs, a_fe, a_bz;
    logic b_lr, b_sd, b_sv, b_fs, b_fe, b_bz;

    int n_checks = 0;
    int n_fail   = 0;

    bit q_msb[$];
    bit q_lsb[$];
    bit m_busy     = 1'b0;
    int m_cnt      = 0;
    int m_loads    = 0;
    bit m_rst_done = 1'b1;
    int dut_beats  = 0;
    int dut_ends   = 0;

    always #5 clk = ~clk;

    piso_serializer_32_bit #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Parallel_Data_In (pdata),
        .Load_Valid_In    (lvalid),
        .Load_Ready_Out   (a_lr),
        .Serial_Data_Out  (a_sd),
        .Serial_Valid_Out (a_sv),
        .Serial_Ready_In  (sready),
        .Frame_Start_Out  (a_fs),
        .Frame_End_Out    (a_fe),
        .Busy_Out         (a_bz)
    );

    piso_serializer_32_bit #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Parallel_Data_In (pdata),
        .Load_Valid_In    (lvalid),
        .Load_Ready_Out   (b_lr),
        .Serial_Data_Out  (b_sd),
        .Serial_Valid_Out (b_sv),
        .Serial_Ready_In  (sready),
        .Frame_Start_Out  (b_fs),
        .Frame_End_Out    (b_fe),
        .Busy_Out         (b_bz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at posedge.
    task automatic run_cycle();
        logic e_end, e_ready, e_start;
        bit   la, ba;
        #1;
        e_end   = m_busy && (m_cnt == 31);
        e_start = m_busy && (m_cnt == 0);
        e_ready = !rst && (!m_busy || (e_end && sready));
        chk("msb_load_ready", 32'(a_lr), 32'(e_ready));
        chk("lsb_load_ready", 32'(b_lr), 32'(e_ready));
        chk("msb_valid",      32'(a_sv), 32'(m_busy));
        chk("lsb_valid",      32'(b_sv), 32'(m_busy));
        chk("msb_busy",       32'(a_bz), 32'(m_busy));
        chk("lsb_busy",       32'(b_bz), 32'(m_busy));
        chk("msb_start",      32'(a_fs), 32'(e_start));
        chk("lsb_start",      32'(b_fs), 32'(e_start));
        chk("msb_end",        32'(a_fe), 32'(e_end));
        chk("lsb_end",        32'(b_fe), 32'(e_end));
        if (m_busy) begin
            chk("msb_data", 32'(a_sd), (q_msb.size() > 0) ? 32'(q_msb[0]) : 'x);
            chk("lsb_data", 32'(b_sd), (q_lsb.size() > 0) ? 32'(q_lsb[0]) : 'x);
        end
        if (m_rst_done) begin
            chk("msb_rst_data", 32'(a_sd), 32'd0);
            chk("lsb_rst_data", 32'(b_sd), 32'd0);
        end
        if (a_sv && sready) dut_beats++;
        if (a_fe) dut_ends++;
        la = lvalid && e_ready;
        ba = m_busy && sready;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            q_msb.delete();
            q_lsb.delete();
            m_rst_done = 1'b1;
        end else begin
            m_rst_done = 1'b0;
            if (ba) begin
                void'(q_msb.pop_front());
                void'(q_lsb.pop_front());
                if (m_cnt == 31) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (la) begin
                for (int i = 31; i >= 0; i--) q_msb.push_back(pdata[i]);
                for (int i = 0; i < 32; i++)  q_lsb.push_back(pdata[i]);
                m_busy = 1'b1;
                m_cnt  = 0;
                m_loads++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int b0;
        int e0;
        int l0;
        logic held;

        // 1: reset for 3 cycles while a word is offered
        rst    = 1'b1;
        lvalid = 1'b1;
        pdata  = 32'hCAFEF00D;
        sready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        repeat (2) run_cycle();
        rst    = 1'b0;
        lvalid = 1'b0;
        run_cycle();
        run_cycle();

        // 2: MSB-first single word, input changes after accept
        pdata  = 32'hA5000001;
        lvalid = 1'b1;
        sready = 1'b1;
        run_cycle();
        lvalid = 1'b0;
        pdata  = $urandom;
        b0 = dut_beats;
        repeat (34) run_cycle();
        chk("t2_beats", 32'(dut_beats - b0), 32'd32);

        // 3: back-to-back words with no idle gap
        l0 = m_loads;
        b0 = dut_beats;
        pdata  = 32'hFFFF0000;
        lvalid = 1'b1;
        run_cycle();
        pdata = 32'h0000FFFF;
        for (int i = 0; i < 40 && m_loads < l0 + 2; i++) run_cycle();
        lvalid = 1'b0;
        repeat (34) run_cycle();
        chk("t3_beats", 32'(dut_beats - b0), 32'd64);

        // 4: backpressure at beat 7 for 5 cycles
        b0 = dut_beats;
        pdata  = 32'h12345678;
        held   = pdata[24];
        lvalid = 1'b1;
        run_cycle();
        lvalid = 1'b0;
        repeat (7) run_cycle();
        sready = 1'b0;
        repeat (5) begin
            chk("t4_hold", 32'(a_sd), 32'(held));
            run_cycle();
        end
        sready = 1'b1;
        repeat (27) run_cycle();
        chk("t4_beats", 32'(dut_beats - b0), 32'd32);

        // 5: reset at beat 12 discards the word without an end marker
        e0 = dut_ends;
        pdata  = 32'hDEADBEEF;
        lvalid = 1'b1;
        run_cycle();
        lvalid = 1'b0;
        repeat (12) run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        chk("t5_no_end", 32'(dut_ends - e0), 32'd0);
        b0 = dut_beats;
        pdata  = 32'h00000003;
        lvalid = 1'b1;
        run_cycle();
        lvalid = 1'b0;
        repeat (34) run_cycle();
        chk("t5_beats", 32'(dut_beats - b0), 32'd32);

        // 6: LSB-first instance sends bit 0 first
        pdata  = 32'h00000001;
        lvalid = 1'b1;
        run_cycle();
        lvalid = 1'b0;
        chk("t6_first_lsb", 32'(b_sd), 32'd1);
        chk("t6_first_msb", 32'(a_sd), 32'd0);
        repeat (34) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
